// File: rtl/token_sender.sv
// Token sender: stages payload words in a FIFO and emits them as one attribution token followed by a burst of data tokens.
// Latency: the attribution token is valid the cycle after I_Start; a FIFO word written into an empty FIFO can be presented the next cycle.
// Backpressure: I_BTk.n=1 holds O_FTk unchanged, and nothing is popped. I_BTk.t=1 aborts the burst and flushes the FIFO.
//
// Ports:
//   clock, reset          sole rising-edge clock; asynchronous active-low reset
//   I_Start/I_Length/I_Mode/I_Cond   burst start pulse and burst parameters, latched in IDLE
//   I_Wr/I_Wr_Data/O_Full            staging-FIFO write side; writes while full are dropped
//   O_FTk / I_BTk                    forward token (v,a,c,r,d) and backward token (n,t,v,c)
//   O_Busy, O_Abort                  FSM not idle; one-cycle pulse when a burst is terminated
//   O_Nack_Cnt                       (only with TOKEN_SENDER_NACK_STAT_EN) saturating count of nacked cycles
//
// Optional feature macro: TOKEN_SENDER_NACK_STAT_EN

package token_sender_pkg;

  localparam int TK_DATA_W = 32;

  typedef struct packed {
    logic                 v;   // token valid
    logic                 a;   // attribution (1) or data (0) token
    logic                 c;   // burst condition bit
    logic                 r;   // last token of the burst
    logic [TK_DATA_W-1:0] d;   // payload
  } FTk_t;

  typedef struct packed {
    logic n;   // not-ready: hold the current forward token
    logic t;   // terminate the current burst
    logic v;
    logic c;
  } BTk_t;

endpackage

module token_sender
  import token_sender_pkg::*;
#(
  parameter int WIDTH_DATA   = 32,   // should equal TK_DATA_W, the token payload width
  parameter int WIDTH_LENGTH = 10,
  parameter int DEPTH_FIFO   = 8     // power of two
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Start,
  input  logic [WIDTH_LENGTH-1:0] I_Length,
  input  logic [1:0]              I_Mode,
  input  logic                    I_Cond,
  input  logic                    I_Wr,
  input  logic [WIDTH_DATA-1:0]   I_Wr_Data,
  output logic                    O_Full,
  output FTk_t                    O_FTk,
  input  BTk_t                    I_BTk,
  output logic                    O_Busy,
  output logic                    O_Abort
`ifdef TOKEN_SENDER_NACK_STAT_EN
  ,
  output logic [15:0]             O_Nack_Cnt
`endif
);

  localparam int AW = (DEPTH_FIFO > 1) ? $clog2(DEPTH_FIFO) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]           FULL_CNT = CW'(DEPTH_FIFO);
  localparam logic [WIDTH_LENGTH-1:0] LEN_ONE  = WIDTH_LENGTH'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ATTR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // Burst control
  logic [1:0]              state_q, state_d;
  logic [WIDTH_LENGTH-1:0] len_q, len_d;     // burst length in ATTR, words still to send in DATA
  logic [1:0]              mode_q, mode_d;
  logic                    cond_q, cond_d;

  // Staging FIFO
  logic [WIDTH_DATA-1:0]   mem [DEPTH_FIFO];
  logic [AW-1:0]           rptr_q, rptr_d;
  logic [AW-1:0]           wptr_q, wptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [CW-1:0]           avail;            // entries left after this cycle's pop, before this cycle's write
  logic [WIDTH_DATA-1:0]   head;             // FIFO head as it will be after this edge

  // Forward token register and strobes
  FTk_t                    ftk_q, ftk_d;
  logic                    abort_q;
  logic [TK_DATA_W-1:0]    attr_word;
  logic                    start_ok;
  logic                    terminate;
  logic                    accept;
  logic                    pop;
  logic                    wr_ok;

  // The valid/cond bits of the backward token carry nothing this block needs.
  logic unused_btk;
  assign unused_btk = I_BTk.v ^ I_BTk.c;

  always_comb begin
    start_ok  = I_Start && (state_q == ST_IDLE);
    // Terminate wins over both hold and acceptance.
    terminate = I_BTk.t && (state_q != ST_IDLE);
    accept    = ftk_q.v && !I_BTk.n && !terminate;
    // In DATA every valid token is the FIFO head, so acceptance is the pop.
    pop       = accept && (state_q == ST_DATA);
    // A write arriving together with a flush is discarded along with the FIFO.
    wr_ok     = I_Wr && (count_q != FULL_CNT) && !terminate;
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    mode_d  = mode_q;
    cond_d  = cond_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_ATTR;
          len_d   = I_Length;
          mode_d  = I_Mode;
          cond_d  = I_Cond;
        end
      end
      ST_ATTR: begin
        if (accept) begin
          state_d = (len_q == '0) ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          len_d = len_q - LEN_ONE;
          if (len_q == LEN_ONE) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (terminate) begin
      state_d = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    if (terminate) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      rptr_d  = pop   ? rptr_q + AW'(1) : rptr_q;
      wptr_d  = wr_ok ? wptr_q + AW'(1) : wptr_q;
      count_d = count_q + CW'(wr_ok) - CW'(pop);
    end
    avail = count_q - CW'(pop);
    // When the FIFO drains this cycle, the only possible new head is the word
    // being written right now, which is not in the memory yet.
    head  = (avail == '0) ? I_Wr_Data : mem[rptr_d];
  end

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wptr_q] <= I_Wr_Data;
    end
  end

  // ---------------------------------------------------------------------------
  // Next forward token, built from the post-edge state so O_FTk is registered
  // yet tracks the FIFO head without a bubble.
  // ---------------------------------------------------------------------------
  always_comb begin
    attr_word                       = '0;
    attr_word[30]                   = 1'b1;
    attr_word[29:28]                = mode_d;
    attr_word[8 +: WIDTH_LENGTH]    = len_d;

    ftk_d = '0;
    if (ftk_q.v && I_BTk.n && !terminate) begin
      ftk_d = ftk_q;
    end else begin
      case (state_d)
        ST_ATTR: begin
          ftk_d.v = 1'b1;
          ftk_d.a = 1'b1;
          ftk_d.c = cond_d;
          ftk_d.r = (len_d == '0);
          ftk_d.d = attr_word;
        end
        ST_DATA: begin
          // Empty FIFO gives a bubble; the burst resumes when data arrives.
          if (count_d != '0) begin
            ftk_d.v = 1'b1;
            ftk_d.a = 1'b0;
            ftk_d.c = cond_d;
            ftk_d.r = (len_d == LEN_ONE);
            ftk_d.d = TK_DATA_W'(head);
          end
        end
        default: ftk_d = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      mode_q  <= '0;
      cond_q  <= 1'b0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ftk_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      cond_q  <= cond_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ftk_q   <= ftk_d;
      abort_q <= terminate;
    end
  end

`ifdef TOKEN_SENDER_NACK_STAT_EN
  logic [15:0] nack_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nack_cnt_q <= '0;
    end else if (start_ok) begin
      nack_cnt_q <= '0;
    end else if (ftk_q.v && I_BTk.n && (nack_cnt_q != 16'hFFFF)) begin
      nack_cnt_q <= nack_cnt_q + 16'd1;
    end
  end

  assign O_Nack_Cnt = nack_cnt_q;
`endif

  assign O_FTk   = ftk_q;
  assign O_Full  = (count_q == FULL_CNT);
  assign O_Busy  = (state_q != ST_IDLE);
  assign O_Abort = abort_q;

endmodule
